// File: rtl/toi2s_pkg.sv
// Shared S/PDIF framing constants and the slot classification used by the encoder.
package toi2s_pkg;

  localparam int unsigned AUDIO_W   = 24;
  localparam int unsigned BLOCK_LEN = 192;
  localparam int unsigned SLOT_CNT  = 32;

  // Preamble half-cell patterns, first half-cell in bit 7.
  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  typedef enum logic [2:0] {
    SLOT_PRE,
    SLOT_AUDIO,
    SLOT_VALID,
    SLOT_USER,
    SLOT_CHAN,
    SLOT_PARITY
  } slot_kind_e;

  function automatic slot_kind_e slot_kind(input logic [4:0] slot);
    slot_kind_e k;
    if (slot < 5'd4) begin
      k = SLOT_PRE;
    end else if (slot < 5'd28) begin
      k = SLOT_AUDIO;
    end else begin
      case (slot)
        5'd28:   k = SLOT_VALID;
        5'd29:   k = SLOT_USER;
        5'd30:   k = SLOT_CHAN;
        default: k = SLOT_PARITY;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/spdif_bmc_enc.sv
// Biphase-mark line driver: preamble half-cells pass through, data cells toggle at start and mid-cell for a 1.
module spdif_bmc_enc (
  input  logic clk_in,
  input  logic resetb,
  input  logic clear,
  input  logic tick,
  input  logic is_pre,
  input  logic pre_level,
  input  logic cell_bit,
  input  logic second_half,
  input  logic sub_end,
  output logic tx,
  output logic last_level
);

  logic tx_next;

  always_comb begin
    tx_next = tx;
    if (is_pre) begin
      tx_next = pre_level;
    end else if (!second_half || cell_bit) begin
      tx_next = ~tx;
    end
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      tx         <= 1'b0;
      last_level <= 1'b0;
    end else if (clear) begin
      tx         <= 1'b0;
      last_level <= 1'b0;
    end else if (tick) begin
      tx <= tx_next;
      if (sub_end) begin
        last_level <= tx_next;
      end
    end
  end

endmodule

// File: rtl/spdif_encoder.sv
// S/PDIF transmitter: tick divider, subframe/frame/block counters, one-pair holding register and slot mux.
module spdif_encoder
  import toi2s_pkg::*;
#(
  parameter int unsigned SAMPLE_W = AUDIO_W
) (
  input  logic                clk_in,
  input  logic                resetb,
  input  logic                ena,
  input  logic [7:0]          div_in,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [31:0]         cs_word,
  output logic                tx_out,
  output logic                frame_start,
  output logic                underrun
);

  localparam int unsigned HC_W       = $clog2(2 * SLOT_CNT);
  localparam logic [7:0]  LAST_FRAME = 8'(BLOCK_LEN - 1);

  logic [7:0]          tick_cnt;
  logic [7:0]          div_q;
  logic [7:0]          div_lim;
  logic                tick;
  logic [HC_W-1:0]     hc;
  logic                sub;
  logic [7:0]          frame;
  logic                frame_head;
  logic                full;
  logic [SAMPLE_W-1:0] hold_l, hold_r;
  logic [SAMPLE_W-1:0] cur_l, cur_r;
  logic                cur_v;
  logic [4:0]          slot;
  logic [4:0]          bit_idx;
  slot_kind_e          kind;
  logic [SAMPLE_W-1:0] samp;
  logic                c_bit;
  logic                parity;
  logic                cell_bit;
  logic [7:0]          pre_pat;
  logic                pre_bit;
  logic                last_level;

  // div_in is sampled live on the first cycle of each period and held for the rest of it,
  // so a change lands on the next wrap and the first period after reset/enable uses the live value.
  always_comb begin
    div_lim = (tick_cnt == '0) ? div_in : div_q;
    tick    = ena && (tick_cnt == div_lim);
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      tick_cnt <= '0;
      div_q    <= '0;
    end else if (!ena) begin
      tick_cnt <= '0;
      div_q    <= div_in;
    end else begin
      div_q    <= div_lim;
      tick_cnt <= tick ? '0 : tick_cnt + 8'd1;
    end
  end

  assign frame_head = (hc == '0) && !sub;

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      hc    <= '0;
      sub   <= 1'b0;
      frame <= '0;
    end else if (!ena) begin
      hc    <= '0;
      sub   <= 1'b0;
      frame <= '0;
    end else if (tick) begin
      hc <= hc + 1'b1;
      if (hc == '1) begin
        sub <= ~sub;
        if (sub) begin
          frame <= (frame == LAST_FRAME) ? '0 : frame + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= tick && frame_head;
      underrun    <= tick && frame_head && !full;
    end
  end

  // A transfer needs an empty register and the frame-head move needs a full one, so they never collide.
  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      full   <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
      cur_l  <= '0;
      cur_r  <= '0;
      cur_v  <= 1'b0;
    end else if (!ena) begin
      full   <= 1'b0;
      cur_l  <= '0;
      cur_r  <= '0;
      cur_v  <= 1'b0;
    end else begin
      if (sample_valid && !full) begin
        hold_l <= sample_l;
        hold_r <= sample_r;
        full   <= 1'b1;
      end else if (tick && frame_head && full) begin
        full <= 1'b0;
      end
      if (tick && frame_head) begin
        cur_l <= full ? hold_l : '0;
        cur_r <= full ? hold_r : '0;
        cur_v <= !full;
      end
    end
  end

  assign sample_ready = !full;

  always_comb begin
    slot     = hc[HC_W-1:1];
    bit_idx  = slot - 5'd4;
    kind     = slot_kind(slot);
    samp     = sub ? cur_r : cur_l;
    c_bit    = (frame < 8'd32) ? cs_word[frame[4:0]] : 1'b0;
    parity   = (^samp) ^ cur_v ^ c_bit;
    cell_bit = 1'b0;
    case (kind)
      SLOT_AUDIO:  cell_bit = samp[bit_idx];
      SLOT_VALID:  cell_bit = cur_v;
      SLOT_USER:   cell_bit = 1'b0;
      SLOT_CHAN:   cell_bit = c_bit;
      SLOT_PARITY: cell_bit = parity;
      default:     cell_bit = 1'b0;
    endcase
    pre_pat = sub ? PRE_W : ((frame == '0) ? PRE_B : PRE_M);
    pre_bit = pre_pat[3'd7 - hc[2:0]];
  end

  spdif_bmc_enc u_bmc (
    .clk_in      (clk_in),
    .resetb      (resetb),
    .clear       (!ena),
    .tick        (tick),
    .is_pre      (kind == SLOT_PRE),
    .pre_level   (pre_bit ^ last_level),
    .cell_bit    (cell_bit),
    .second_half (hc[0]),
    .sub_end     (hc == '1),
    .tx          (tx_out),
    .last_level  (last_level)
  );

endmodule

// File: tb/tb_spdif_encoder.sv
// Self-checking bench: a half-cell-level line model built from the S/PDIF framing rules, fed by random pairs.
module tb_spdif_encoder;

  logic        clk_in = 1'b0;
  logic        resetb = 1'b0;
  logic        ena = 1'b0;
  logic [7:0]  div_in = 8'd3;
  logic [23:0] sample_l = '0;
  logic [23:0] sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [31:0] cs_word = '0;
  logic        tx_out;
  logic        frame_start;
  logic        underrun;

  spdif_encoder #(.SAMPLE_W(24)) dut (
    .clk_in       (clk_in),
    .resetb       (resetb),
    .ena          (ena),
    .div_in       (div_in),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .cs_word      (cs_word),
    .tx_out       (tx_out),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 clk_in = ~clk_in;

  localparam logic [7:0] PB = 8'b1110_1000;
  localparam logic [7:0] PM = 8'b1110_0010;
  localparam logic [7:0] PW = 8'b1110_0100;

  int checks = 0;
  int failures = 0;

  // line/timing model
  int          ncur, ph, hcg, offer_pct;
  bit          m_full;
  logic [23:0] m_hold_l, m_hold_r;
  logic [63:0] exp_l, exp_r, obs_l, obs_r;
  logic        lvl, prev_tx;
  int          fs_cnt, exp_fs, ur_cnt, exp_urc, fs_pos_bad, ur_pos_bad, glitches, ready_bad;
  int          b_seen, c_seen;
  logic [23:0] dec_l, dec_r;
  logic        dec_vl, dec_vr, dec_cl, dec_cr, dec_pl, dec_pr;

  function automatic logic [63:0] build_sub(input logic [7:0] pre, input logic [23:0] s,
                                            input logic v, input logic c,
                                            input logic lvl_in, output logic lvl_out);
    logic [63:0] h;
    logic [31:0] d;
    logic        lv;
    d       = '0;
    d[27:4] = s;
    d[28]   = v;
    d[30]   = c;
    d[31]   = ^d[30:4];
    h       = '0;
    for (int k = 0; k < 8; k++) h[k] = pre[7-k] ^ lvl_in;
    lv = h[7];
    for (int k = 4; k < 32; k++) begin
      lv = ~lv;
      h[2*k] = lv;
      if (d[k]) lv = ~lv;
      h[2*k+1] = lv;
    end
    lvl_out = lv;
    return h;
  endfunction

  function automatic void decode_sub(input logic [63:0] o, output logic [23:0] s,
                                     output logic v, output logic c, output logic par_ok);
    logic [31:0] b;
    b = '0;
    for (int k = 4; k < 32; k++) b[k] = o[2*k] ^ o[2*k+1];
    s      = b[27:4];
    v      = b[28];
    c      = b[30];
    par_ok = ~^b[31:4];
  endfunction

  task automatic restart_timeline();
    ph = 0; hcg = 0; ncur = 1; m_full = 0; lvl = 1'b0; prev_tx = 1'b0;
    fs_cnt = 0; exp_fs = 0; ur_cnt = 0; exp_urc = 0; fs_pos_bad = 0; ur_pos_bad = 0;
    glitches = 0; ready_bad = 0; b_seen = 0; c_seen = 0;
  endtask

  task automatic start_frame();
    int          fidx;
    logic        cbit, v;
    logic [23:0] sl, sr;
    logic [7:0]  pre;
    fidx = (hcg / 128) % 192;
    cbit = (fidx < 32) ? cs_word[fidx] : 1'b0;
    if (m_full) begin
      sl = m_hold_l; sr = m_hold_r; v = 1'b0; m_full = 0;
    end else begin
      sl = '0; sr = '0; v = 1'b1; exp_urc++;
    end
    exp_fs++;
    pre   = (fidx == 0) ? PB : PM;
    exp_l = build_sub(pre, sl, v, cbit, lvl, lvl);
    exp_r = build_sub(PW, sr, v, cbit, lvl, lvl);
  endtask

  task automatic end_subframe();
    logic [7:0] p8;
    int         sf;
    sf = hcg / 64 - 1;
    checks++;
    if (sf % 2 == 0) begin
      if (obs_l !== exp_l) begin
        failures++;
        $display("FAIL left_subframe frame %0d: got %h expected %h", sf / 2, obs_l, exp_l);
      end
    end else begin
      if (obs_r !== exp_r) begin
        failures++;
        $display("FAIL right_subframe frame %0d: got %h expected %h", sf / 2, obs_r, exp_r);
      end
      for (int k = 0; k < 8; k++) p8[7-k] = obs_l[k] ^ obs_l[0] ^ 1'b1;
      if (p8 == PB) b_seen++;
      decode_sub(obs_l, dec_l, dec_vl, dec_cl, dec_pl);
      decode_sub(obs_r, dec_r, dec_vr, dec_cr, dec_pr);
      if (dec_cl) c_seen++;
    end
  endtask

  task automatic step();
    bit tick_e, head, xfer;
    int idx;
    if (ph == 0) ncur = int'(div_in) + 1;
    tick_e = (ph == ncur - 1);
    head   = tick_e && (hcg % 128 == 0);
    if (sample_ready !== !m_full) ready_bad++;
    xfer = sample_valid && !m_full;
    @(posedge clk_in);
    if (head) start_frame();
    if (xfer) begin
      m_full = 1; m_hold_l = sample_l; m_hold_r = sample_r;
    end
    #1;
    ph = tick_e ? 0 : ph + 1;
    if (tick_e) begin
      idx = hcg % 64;
      if ((hcg / 64) % 2 == 0) obs_l[idx] = tx_out;
      else                     obs_r[idx] = tx_out;
    end else if (tx_out !== prev_tx) begin
      glitches++;
    end
    prev_tx = tx_out;
    if (frame_start === 1'b1) begin fs_cnt++; if (!head) fs_pos_bad++; end
    if (underrun === 1'b1)    begin ur_cnt++; if (!head) ur_pos_bad++; end
    if (tick_e) begin
      hcg++;
      if (hcg % 64 == 0) end_subframe();
    end
    if (xfer || !sample_valid) begin
      sample_valid = (int'($urandom_range(99)) < offer_pct);
      sample_l     = 24'($urandom);
      sample_r     = 24'($urandom);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_totals(input string tag);
    checks++;
    if (fs_cnt != exp_fs) begin failures++; $display("FAIL %s frame_start_count: got %0d expected %0d", tag, fs_cnt, exp_fs); end
    checks++;
    if (ur_cnt != exp_urc) begin failures++; $display("FAIL %s underrun_count: got %0d expected %0d", tag, ur_cnt, exp_urc); end
    checks++;
    if (fs_pos_bad + ur_pos_bad != 0) begin failures++; $display("FAIL %s pulse_position: got %0d misplaced expected 0", tag, fs_pos_bad + ur_pos_bad); end
    checks++;
    if (glitches != 0) begin failures++; $display("FAIL %s off_tick_change: got %0d expected 0", tag, glitches); end
    checks++;
    if (ready_bad != 0) begin failures++; $display("FAIL %s sample_ready: got %0d bad cycles expected 0", tag, ready_bad); end
  endtask

  task automatic go_idle();
    ena = 1'b0; sample_valid = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
  endtask

  task automatic enable_at(input logic [7:0] div);
    div_in = div;
    restart_timeline();
    ena = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({tx_out, sample_ready, frame_start, underrun} !== 4'b0100) begin
      failures++;
      $display("FAIL %s idle_outputs: got tx/rdy/fs/ur=%b expected 0100", tag, {tx_out, sample_ready, frame_start, underrun});
    end
  endtask

  task automatic test_reset();
    #1;
    check_idle_outputs("reset_asserted");
    @(posedge clk_in); #1;
    resetb = 1'b1;
    repeat (4) @(posedge clk_in);
    #1;
    check_idle_outputs("reset_released_idle");
  endtask

  task automatic test_basic();
    enable_at(8'd3);
    offer_pct = 0;
    sample_l = 24'h000001; sample_r = 24'h800000; sample_valid = 1'b1;
    run_cycles(4 * 128);
    checks++;
    if (dec_l !== 24'h000001 || dec_r !== 24'h800000) begin
      failures++; $display("FAIL basic_decode: got %h/%h expected 000001/800000", dec_l, dec_r);
    end
    checks++;
    if ({dec_vl, dec_vr, dec_pl, dec_pr} !== 4'b0011) begin
      failures++; $display("FAIL basic_v_parity: got vl/vr/pl/pr=%b expected 0011", {dec_vl, dec_vr, dec_pl, dec_pr});
    end
    run_cycles(4 * 128);
    checks++;
    if ({dec_l, dec_r, dec_vl, dec_vr} !== {48'h0, 2'b11}) begin
      failures++; $display("FAIL basic_zero_fill: got %h/%h v=%b%b expected 000000/000000 v=11", dec_l, dec_r, dec_vl, dec_vr);
    end
    check_totals("basic");
    go_idle();
  endtask

  task automatic test_underrun();
    enable_at(8'd3);
    offer_pct = 0;
    run_cycles(3 * 4 * 128);
    checks++;
    if (ur_cnt != 3) begin failures++; $display("FAIL underrun_pulses: got %0d expected 3", ur_cnt); end
    checks++;
    if ({dec_l, dec_r, dec_vl, dec_vr} !== {48'h0, 2'b11}) begin
      failures++; $display("FAIL underrun_zero_fill: got %h/%h v=%b%b expected 000000/000000 v=11", dec_l, dec_r, dec_vl, dec_vr);
    end
    check_totals("underrun");
    go_idle();
  endtask

  task automatic test_random_div_change();
    cs_word = $urandom;
    enable_at(8'd3);
    offer_pct = 50;
    run_cycles(700 + int'($urandom_range(20)));
    div_in = 8'd1;
    run_cycles(900);
    check_totals("div_change");
    go_idle();
  endtask

  task automatic test_back_to_back();
    cs_word = 32'h0000_0004;
    enable_at(8'd0);
    offer_pct = 100;
    run_cycles(400 * 128);
    checks++;
    if (b_seen != 3) begin failures++; $display("FAIL b_preamble_count: got %0d expected 3", b_seen); end
    checks++;
    if (c_seen != 3) begin failures++; $display("FAIL c_bit_count: got %0d expected 3", c_seen); end
    check_totals("back_to_back");
    go_idle();
  endtask

  task automatic test_abort();
    cs_word = $urandom;
    enable_at(8'd2);
    offer_pct = 60;
    run_cycles(100 + int'($urandom_range(30)));
    check_totals("pre_ena_drop");
    ena = 1'b0; sample_valid = 1'b0;
    @(posedge clk_in); #1;
    check_idle_outputs("ena_drop");
    enable_at(8'd2);
    offer_pct = 60;
    run_cycles(3 * 128 + 200);
    check_totals("after_reenable");
    #3;
    resetb = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(posedge clk_in); #1;
    resetb = 1'b1;
    enable_at(8'd2);
    offer_pct = 40;
    run_cycles(3 * 128 * 2);
    check_totals("after_reset");
    go_idle();
  endtask

  initial begin
    restart_timeline();
    offer_pct = 0;
    test_reset();
    test_basic();
    test_underrun();
    test_random_div_change();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
